// File: rtl/max_pool_ctrl_pkg.sv
// Shared definitions for the 2x2 signed max-pool sequencer: default sizes,
// FSM state encoding and the lane order of the 128-bit pooling window.
package max_pool_ctrl_pkg;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned MAX_PAIRS_DEF = 256;
   localparam int unsigned CNT_W_DEF     = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVEN  = 2'd1,
      ODD   = 2'd2,
      FLUSH = 2'd3
   } state_e;

   // Window lanes: top row comes from the line buffer, bottom row from the live beat
   localparam int unsigned LANE_TL = 0;
   localparam int unsigned LANE_TR = 1;
   localparam int unsigned LANE_BL = 2;
   localparam int unsigned LANE_BR = 3;

endpackage

// File: rtl/max_pool_line_buf.sv
// Even-row line buffer: one synchronous write port and a combinational
// read port, DEPTH entries of WIDTH bits (flop array / distributed RAM).
module max_pool_line_buf #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pooling.sv
// 4-input signed maximum over a packed window of four DATA_W lanes.
// Purely combinational; ties return the shared value.
module max_pooling #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [4*DATA_W-1:0] window_i,
   output logic [DATA_W-1:0]   max_o
);

   logic signed [DATA_W-1:0] l0, l1, l2, l3, m01, m23;

   assign l0  = window_i[0*DATA_W +: DATA_W];
   assign l1  = window_i[1*DATA_W +: DATA_W];
   assign l2  = window_i[2*DATA_W +: DATA_W];
   assign l3  = window_i[3*DATA_W +: DATA_W];
   assign m01 = (l0 > l1) ? l0 : l1;
   assign m23 = (l2 > l3) ? l2 : l3;
   assign max_o = (m01 > m23) ? m01 : m23;

endmodule

// File: rtl/max_pool_ctrl.sv
// 2x2 signed max-pool sequencer: buffers even rows, pools against odd rows.
// Optional MAX_POOL_RELU_EN clamps negative pooled results to zero.
module max_pool_ctrl
   import max_pool_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_PAIRS = MAX_PAIRS_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_start,
   input  logic [CNT_W-1:0]    cfg_pairs,
   input  logic [CNT_W-1:0]    cfg_rows,
   output logic                busy,
   output logic                done,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*DATA_W-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last
);

   localparam int unsigned      AW    = $clog2(MAX_PAIRS);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PAIRS);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    col_q, col_d, row_q, row_d;
   logic [CNT_W-1:0]    pairs_q, pairs_d, rows_q, rows_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;

   logic                buf_we;
   logic [2*DATA_W-1:0] buf_rdata;
   logic [4*DATA_W-1:0] window;
   logic [DATA_W-1:0]   max_raw, pooled;
   logic [CNT_W-1:0]    pairs_sat, rows_sat;
   logic                out_fire, col_last, row_last;

   max_pool_line_buf #(
      .WIDTH (2*DATA_W),
      .DEPTH (MAX_PAIRS),
      .AW    (AW)
   ) u_line_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (col_q[AW-1:0]),
      .wdata_i (in_data),
      .raddr_i (col_q[AW-1:0]),
      .rdata_o (buf_rdata)
   );

   assign window[LANE_TL*DATA_W +: DATA_W] = buf_rdata[DATA_W-1:0];
   assign window[LANE_TR*DATA_W +: DATA_W] = buf_rdata[2*DATA_W-1:DATA_W];
   assign window[LANE_BL*DATA_W +: DATA_W] = in_data[DATA_W-1:0];
   assign window[LANE_BR*DATA_W +: DATA_W] = in_data[2*DATA_W-1:DATA_W];

   max_pooling #(.DATA_W(DATA_W)) u_max (
      .window_i (window),
      .max_o    (max_raw)
   );

`ifdef MAX_POOL_RELU_EN
   assign pooled = max_raw[DATA_W-1] ? '0 : max_raw;
`else
   assign pooled = max_raw;
`endif

   assign pairs_sat = (cfg_pairs > MAX_C) ? MAX_C : cfg_pairs;
   assign rows_sat  = (cfg_rows  > MAX_C) ? MAX_C : cfg_rows;
   assign out_fire  = out_valid_q && out_ready;
   assign col_last  = (col_q == pairs_q - ONE_C);
   assign row_last  = (row_q == rows_q - ONE_C);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      pairs_d     = pairs_q;
      rows_d      = rows_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      buf_we      = 1'b0;
      in_ready    = 1'b0;

      if (out_fire) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               pairs_d = pairs_sat;
               rows_d  = rows_sat;
               if (pairs_sat == '0 || rows_sat == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = EVEN;
                  busy_d  = 1'b1;
                  col_d   = '0;
                  row_d   = '0;
               end
            end
         end
         EVEN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               buf_we = 1'b1;
               if (col_last) begin
                  col_d   = '0;
                  state_d = ODD;
               end else begin
                  col_d = col_q + ONE_C;
               end
            end
         end
         ODD: begin
            // A result may load in the same cycle the previous one drains
            in_ready = !out_valid_q || out_ready;
            if (in_valid && in_ready) begin
               out_valid_d = 1'b1;
               out_data_d  = pooled;
               out_last_d  = 1'b0;
               if (col_last) begin
                  col_d = '0;
                  if (row_last) begin
                     out_last_d = 1'b1;
                     state_d    = FLUSH;
                  end else begin
                     row_d   = row_q + ONE_C;
                     state_d = EVEN;
                  end
               end else begin
                  col_d = col_q + ONE_C;
               end
            end
         end
         FLUSH: begin
            if (out_fire && out_last_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         pairs_q     <= '0;
         rows_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         pairs_q     <= pairs_d;
         rows_q      <= rows_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: doc/max_pool_ctrl.md
Name: max_pool_ctrl

Overview:
Sequencer for the 2x2 signed max-pooling reduction on the accelerator datapath. Accepts a row-major stream of 32-bit signed pixels, two pixels per beat. Buffers each even row in a line buffer and, while the following odd row streams in, assembles 128-bit 2x2 windows, drives them through the 4-input max reduction and emits one pooled result per window. Sits between the input DMA/unpack stage and the result write-back FIFO; configured per frame by the host-facing CSR block.

Parameters:
DATA_W, 32, pixel width (signed two's complement); beat is 2*DATA_W.
MAX_PAIRS, 256, line-buffer depth = maximum pixel pairs (output columns) per row.
CNT_W, 9, width of column/row counters and config fields; must hold MAX_PAIRS.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse: latch config and start a frame
cfg_pairs  in  CNT_W  pixel pairs per row (output columns)
cfg_rows  in  CNT_W  row pairs per frame (output rows)
busy  out  1  high from accepted cfg_start until done
done  out  1  one-cycle pulse when frame complete and last result consumed
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  2*DATA_W  [DATA_W-1:0] left pixel, [2*DATA_W-1:DATA_W] right pixel
out_valid  out  1  pooled result valid
out_ready  in  1  downstream ready
out_data  out  DATA_W  pooled maximum
out_last  out  1  qualifies final result of frame

Behaviour:
- Clock domain/reset: one clock; reset is synchronous and active-high. Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_data=0, state=IDLE, counters=0. Line-buffer contents not cleared. Reset mid-frame abandons the frame; no done pulse.
- States: IDLE, EVEN, ODD, FLUSH.
- IDLE: in_ready=0. On cfg_start, latch cfg_pairs/cfg_rows; values > MAX_PAIRS saturate to MAX_PAIRS. If either field is 0, pulse done next cycle and stay IDLE. Otherwise go to EVEN with col=0, row=0. cfg_start is ignored while busy.
- EVEN: in_ready=1. Each accepted beat writes buf[col]; col++. Accepting col==pairs-1 sets col=0 and moves to ODD.
- ODD: in_ready = !out_valid || out_ready (single output register, full throughput). Each accepted beat forms a window: [31:0]=buf[col] left, [63:32]=buf[col] right, [95:64]=in left, [127:96]=in right. The signed maximum of the window is registered into out_data with out_valid=1 on the next cycle (latency 1). Line buffer read is combinational (flop array/distributed RAM).
- End of ODD row: accepting col==pairs-1 sets col=0. If row==rows-1, set out_last with that result and go to FLUSH; else row++ and go to EVEN.
- FLUSH: in_ready=0. When the out_last result handshakes, pulse done, drop busy and go to IDLE.
- Output: out_valid clears on handshake unless a new result loads the same cycle. out_data/out_last hold while out_valid && !out_ready.
- Compare: full signed DATA_W compare; ties yield the equal value. 0x80000000 < 0x7FFFFFFF.

Optional Feature:
MAX_POOL_RELU_EN: when defined, a negative pooled result is replaced by 0 before the output register; same latency. When undefined, the raw signed maximum is output.

Decomposition:
- Shared package/header: DATA_W and MAX_PAIRS defaults, state encodings (IDLE=0, EVEN=1, ODD=2, FLUSH=3), window lane-order constants.
- Sub-modules: the line buffer is a natural sub-module, max_pool_line_buf (write port plus combinational read port, MAX_PAIRS x 2*DATA_W). The 4-input signed reduction uses the team's existing max_pooling datapath block, instantiated unchanged.

Test Plan:
- pairs=2, rows=1; beats (1,5),(-3,2),(7,0),(4,9) -> outputs 7 then 9 (out_last=1), then one done pulse.
- Extremes: rows=pairs=1; beats (0x80000000,0x7FFFFFFF),(0xFFFFFFFF,0) -> 0x7FFFFFFF. All-negative window (-4,-2,-9,-3) -> -2, or 0 with MAX_POOL_RELU_EN.
- Backpressure: pairs=4, rows=2, out_ready toggled 1-0-0-1 -> no lost or duplicated results, in_ready low in ODD while the output is stalled, exactly 8 outputs in order.
- cfg_pairs=0 -> done one cycle after cfg_start, no in_ready. cfg_pairs=300 with MAX_PAIRS=256 -> 256 columns per row.
- Reset asserted mid-ODD row -> next cycle busy=0, out_valid=0, in_ready=0. A new frame then completes correctly.
- cfg_start re-pulsed while busy -> ignored; original frame output count and done timing unchanged.
